// File: rtl/mips_defs.sv
// Shared MIPS32 core definitions: memory opcodes and LSU FSM states.
package mips_defs;

  localparam logic [7:0] EXE_LB = 8'h90;
  localparam logic [7:0] EXE_LW = 8'h92;
  localparam logic [7:0] EXE_SB = 8'h98;
  localparam logic [7:0] EXE_SW = 8'h9A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [7:0] op);
    return (op == EXE_LB) || (op == EXE_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB) || (op == EXE_SW);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data bus req/ack handshake between mem_lsu (master) and memory (slave).
interface mem_lsu_if;
  logic        dbus_req_o;
  logic [3:0]  dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;

  modport master (
    output dbus_req_o, dbus_we_o,
    output dbus_addr_o, dbus_wdata_o,
    input  dbus_ack_i, dbus_rdata_i
  );

  modport slave (
    input  dbus_req_o, dbus_we_o,
    input  dbus_addr_o, dbus_wdata_o,
    output dbus_ack_i, dbus_rdata_i
  );
endinterface

// File: rtl/lsu_lane_gen.sv
// Byte-lane mask, write enables and big-endian store data for the LSU.
module lsu_lane_gen
  import mips_defs::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] din_i,
  output logic [3:0]  dre_o,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o
);

  logic [3:0] lane;

  assign lane = 4'b1000 >> addr_i;

  always_comb begin
    dre_o   = 4'h0;
    we_o    = 4'h0;
    wdata_o = 32'h0;
    unique case (1'b1)
      aluop_i == EXE_LB: dre_o = lane;
      aluop_i == EXE_LW: dre_o = 4'hF;
      aluop_i == EXE_SB: begin
        dre_o   = lane;
        we_o    = lane;
        wdata_o = {4{din_i[7:0]}};
      end
      aluop_i == EXE_SW: begin
        dre_o   = 4'hF;
        we_o    = 4'hF;
        wdata_o = {din_i[7:0], din_i[15:8],
                   din_i[23:16], din_i[31:24]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit with MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned LW/SW.
module mem_lsu
  import mips_defs::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        cpu_clk_50M,
  input  logic        rst_n,
  input  logic [7:0]  mem_aluop_i,
  input  logic [4:0]  mem_wa_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wd_i,
  input  logic [31:0] mem_din_i,
  input  logic        mem_whilo_i,
  input  logic [63:0] mem_hilo_i,
  mem_lsu_if.master   dbus,
  output logic        stall_req_o,
  output logic        bus_err_o,
  output logic [4:0]  wb_wa_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_dreg_o,
  output logic        wb_mreg_o,
  output logic [3:0]  wb_dre_o,
  output logic [31:0] wb_dm_o,
  output logic        wb_whilo_o,
  output logic [63:0] wb_hilo_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [3:0]  hold_we_q, hold_we_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;

  logic [3:0]  lane_dre, lane_we;
  logic [31:0] lane_wdata;
  logic        is_ld, is_mem, misal, misal_hit;
  logic        req_c, err_c;
  logic [3:0]  we_c;
  logic [31:0] addr_c, wdata_c;

  logic [4:0]  wa_q, wa_d;
  logic        wreg_q, wreg_d;
  logic [31:0] dreg_q, dreg_d;
  logic        mreg_q, mreg_d;
  logic [3:0]  dre_q, dre_d;
  logic [31:0] dm_q, dm_d;
  logic        whilo_q, whilo_d;
  logic [63:0] hilo_q, hilo_d;

  lsu_lane_gen u_lane_gen (
    .aluop_i (mem_aluop_i),
    .addr_i  (mem_wd_i[1:0]),
    .din_i   (mem_din_i),
    .dre_o   (lane_dre),
    .we_o    (lane_we),
    .wdata_o (lane_wdata)
  );

  assign is_ld  = is_load(mem_aluop_i);
  assign is_mem = is_ld | is_store(mem_aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = ((mem_aluop_i == EXE_LW) ||
                  (mem_aluop_i == EXE_SW)) &&
                 (mem_wd_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign misal_hit = (state_q == IDLE) & is_mem & misal;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_addr_d  = hold_addr_q;
    hold_we_d    = hold_we_q;
    hold_wdata_d = hold_wdata_q;
    req_c        = 1'b0;
    we_c         = 4'h0;
    addr_c       = 32'h0;
    wdata_c      = 32'h0;
    err_c        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (misal_hit) begin
          err_c = 1'b1;
        end else if (is_mem) begin
          req_c   = 1'b1;
          we_c    = lane_we;
          addr_c  = {mem_wd_i[31:2], 2'b00};
          wdata_c = lane_wdata;
          if (!dbus.dbus_ack_i) begin
            hold_addr_d  = addr_c;
            hold_we_d    = we_c;
            hold_wdata_d = wdata_c;
            cnt_d        = 8'd0;
            state_d      = WAIT;
          end
        end
      end
      // Replay the latched request so upstream churn cannot disturb it
      WAIT: begin
        req_c   = 1'b1;
        we_c    = hold_we_q;
        addr_c  = hold_addr_q;
        wdata_c = hold_wdata_q;
        if (dbus.dbus_ack_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ABORT: begin
        err_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the bus immediately, not at the next edge
  assign dbus.dbus_req_o   = req_c & rst_n;
  assign dbus.dbus_we_o    = we_c & {4{rst_n}};
  assign dbus.dbus_addr_o  = addr_c & {32{rst_n}};
  assign dbus.dbus_wdata_o = wdata_c & {32{rst_n}};
  assign stall_req_o = dbus.dbus_req_o & ~dbus.dbus_ack_i;
  assign bus_err_o   = err_c & rst_n;

  always_comb begin
    wa_d    = 5'd0;
    wreg_d  = 1'b0;
    dreg_d  = 32'h0;
    mreg_d  = 1'b0;
    dre_d   = 4'h0;
    dm_d    = 32'h0;
    whilo_d = 1'b0;
    hilo_d  = 64'h0;
    if (!stall_req_o && !misal_hit) begin
      wa_d    = mem_wa_i;
      wreg_d  = mem_wreg_i;
      dreg_d  = mem_wd_i;
      whilo_d = mem_whilo_i;
      hilo_d  = mem_hilo_i;
      dm_d    = dm_q;
      if (is_ld) begin
        mreg_d = 1'b1;
        dre_d  = lane_dre;
        dm_d   = (state_q == ABORT) ? 32'h0
                                    : dbus.dbus_rdata_i;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      hold_addr_q  <= 32'h0;
      hold_we_q    <= 4'h0;
      hold_wdata_q <= 32'h0;
      wa_q         <= 5'd0;
      wreg_q       <= 1'b0;
      dreg_q       <= 32'h0;
      mreg_q       <= 1'b0;
      dre_q        <= 4'h0;
      dm_q         <= 32'h0;
      whilo_q      <= 1'b0;
      hilo_q       <= 64'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_addr_q  <= hold_addr_d;
      hold_we_q    <= hold_we_d;
      hold_wdata_q <= hold_wdata_d;
      wa_q         <= wa_d;
      wreg_q       <= wreg_d;
      dreg_q       <= dreg_d;
      mreg_q       <= mreg_d;
      dre_q        <= dre_d;
      dm_q         <= dm_d;
      whilo_q      <= whilo_d;
      hilo_q       <= hilo_d;
    end
  end

  assign wb_wa_o    = wa_q;
  assign wb_wreg_o  = wreg_q;
  assign wb_dreg_o  = dreg_q;
  assign wb_mreg_o  = mreg_q;
  assign wb_dre_o   = dre_q;
  assign wb_dm_o    = dm_q;
  assign wb_whilo_o = whilo_q;
  assign wb_hilo_o  = hilo_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu against a transaction-level model.
module tb_mem_lsu;
  import mips_defs::*;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_aluop_i;
  logic [4:0]  mem_wa_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wd_i;
  logic [31:0] mem_din_i;
  logic        mem_whilo_i;
  logic [63:0] mem_hilo_i;
  logic        stall_req_o, bus_err_o;
  logic [4:0]  wb_wa_o;
  logic        wb_wreg_o;
  logic [31:0] wb_dreg_o;
  logic        wb_mreg_o;
  logic [3:0]  wb_dre_o;
  logic [31:0] wb_dm_o;
  logic        wb_whilo_o;
  logic [63:0] wb_hilo_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_dm;

  mem_lsu_if bus ();

  mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .cpu_clk_50M (clk),
    .rst_n       (rst_n),
    .mem_aluop_i (mem_aluop_i),
    .mem_wa_i    (mem_wa_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wd_i    (mem_wd_i),
    .mem_din_i   (mem_din_i),
    .mem_whilo_i (mem_whilo_i),
    .mem_hilo_i  (mem_hilo_i),
    .dbus        (bus),
    .stall_req_o (stall_req_o),
    .bus_err_o   (bus_err_o),
    .wb_wa_o     (wb_wa_o),
    .wb_wreg_o   (wb_wreg_o),
    .wb_dreg_o   (wb_dreg_o),
    .wb_mreg_o   (wb_mreg_o),
    .wb_dre_o    (wb_dre_o),
    .wb_dm_o     (wb_dm_o),
    .wb_whilo_o  (wb_whilo_o),
    .wb_hilo_o   (wb_hilo_o)
  );

  always #5 clk = ~clk;

  logic [139:0] wb_act;
  logic [68:0]  bus_act;
  assign wb_act = {wb_wa_o, wb_wreg_o, wb_dreg_o, wb_mreg_o,
                   wb_dre_o, wb_dm_o, wb_whilo_o, wb_hilo_o};
  assign bus_act = {bus.dbus_req_o, bus.dbus_we_o,
                    bus.dbus_addr_o, bus.dbus_wdata_o};

  task automatic drive_nop();
    mem_aluop_i = 8'h00;
    mem_wa_i    = 5'd0;
    mem_wreg_i  = 1'b0;
    mem_wd_i    = 32'h0;
    mem_din_i   = 32'h0;
    mem_whilo_i = 1'b0;
    mem_hilo_i  = 64'h0;
  endtask

  // One instruction through MEM; called at posedge+1, returns at posedge+1.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int nwait, input bit tog,
                        output int nreq, output int nstall,
                        output int nerr);
    logic [4:0]   wa;
    logic         wr, wh;
    logic [63:0]  hl;
    bit           ld, st, mem, mis, to;
    int           ncyc;
    logic [3:0]   lane, ewe;
    logic [31:0]  ewd, eaddr;
    logic [139:0] ewb;
    wa = 5'($urandom);
    wr = 1'($urandom);
    wh = 1'($urandom);
    hl = {$urandom, $urandom};
    ld = (op == EXE_LB) || (op == EXE_LW);
    st = (op == EXE_SB) || (op == EXE_SW);
    mem = ld || st;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = ((op == EXE_LW) || (op == EXE_SW)) && (a[1:0] != 2'b00);
`endif
    to = mem && !mis && (nwait > TIMEOUT);
    ncyc = (!mem || mis) ? 1 : (to ? TIMEOUT + 2 : nwait + 1);
    lane = ((op == EXE_LW) || (op == EXE_SW)) ? 4'hF
         : 4'(8 >> a[1:0]);
    ewe = (op == EXE_SB) ? lane : ((op == EXE_SW) ? 4'hF : 4'h0);
    ewd = (op == EXE_SW) ? {<<8{d}}
        : ((op == EXE_SB) ? {4{d[7:0]}} : 32'h0);
    eaddr = {a[31:2], 2'b00};
    nreq = 0;
    nstall = 0;
    nerr = 0;
    for (int k = 0; k < ncyc; k++) begin
      bit ab, ack, ereq, est, eerr;
      ab = to && (k == TIMEOUT + 1);
      if (!mem || mis || ab) ack = 1'($urandom);
      else ack = !to && (k == nwait);
      mem_aluop_i = op;
      mem_wreg_i  = wr;
      mem_whilo_i = wh;
      if (tog && k > 0 && k < ncyc - 1) begin
        mem_wa_i   = 5'($urandom);
        mem_wd_i   = $urandom;
        mem_din_i  = $urandom;
        mem_hilo_i = {$urandom, $urandom};
      end else begin
        mem_wa_i   = wa;
        mem_wd_i   = a;
        mem_din_i  = d;
        mem_hilo_i = hl;
      end
      bus.dbus_ack_i   = ack;
      bus.dbus_rdata_i = ack ? rd : $urandom;
      #1;
      ereq = mem && !mis && !ab;
      est  = ereq && !ack;
      eerr = ab || mis;
      checks++;
      if ({bus.dbus_req_o, stall_req_o, bus_err_o} !== {ereq, est, eerr}) begin
        failures++;
        $display("FAIL ctl op=%h k=%0d req/stall/err got=%b%b%b exp=%b%b%b",
                 op, k, bus.dbus_req_o, stall_req_o, bus_err_o,
                 ereq, est, eerr);
      end
      if (ereq) begin
        checks++;
        if (bus_act[67:0] !== {ewe, eaddr, ewd}) begin
          failures++;
          $display("FAIL bus op=%h k=%0d got=%h exp=%h",
                   op, k, bus_act[67:0], {ewe, eaddr, ewd});
        end
      end
      nreq   += int'(bus.dbus_req_o);
      nstall += int'(stall_req_o);
      nerr   += int'(bus_err_o);
      if (est || mis) begin
        exp_dm = 32'h0;
        ewb = '0;
      end else begin
        if (ld) exp_dm = ab ? 32'h0 : rd;
        ewb = {wa, wr, a, ld, (ld ? lane : 4'h0), exp_dm, wh, hl};
      end
      @(posedge clk);
      #1;
      checks++;
      if (wb_act !== ewb) begin
        failures++;
        $display("FAIL wb op=%h k=%0d got=%h exp=%h", op, k, wb_act, ewb);
      end
    end
    bus.dbus_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_aluop_i = EXE_LW;
    mem_wd_i = $urandom;
    mem_wreg_i = 1'b1;
    bus.dbus_ack_i = 1'b1;
    bus.dbus_rdata_i = $urandom;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus_act, stall_req_o, bus_err_o, wb_act} !== '0) begin
      failures++;
      $display("FAIL reset_hold bus=%h stall=%b err=%b wb=%h",
               bus_act, stall_req_o, bus_err_o, wb_act);
    end
    drive_nop();
    bus.dbus_ack_i = 1'b0;
    rst_n = 1'b1;
    exp_dm = 32'h0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus_act, stall_req_o, bus_err_o, wb_act} !== '0) begin
      failures++;
      $display("FAIL reset_release bus=%h stall=%b err=%b wb=%h",
               bus_act, stall_req_o, bus_err_o, wb_act);
    end
  endtask

  task automatic test_lw_zero_wait();
    int nr, ns, ne;
    run_op(EXE_LW, 32'h100, $urandom, 32'h44332211, 0, 0, nr, ns, ne);
    checks++;
    if ({wb_mreg_o, wb_dre_o, wb_dm_o, 32'(ns)} !==
        {1'b1, 4'hF, 32'h44332211, 32'd0}) begin
      failures++;
      $display("FAIL lw_zero mreg=%b dre=%b dm=%h stalls=%0d exp 1 1111 44332211 0",
               wb_mreg_o, wb_dre_o, wb_dm_o, ns);
    end
  endtask

  task automatic test_sb_wait();
    int nr, ns, ne;
    run_op(EXE_SB, 32'h203, 32'h000000AB, $urandom, 3, 1, nr, ns, ne);
    checks++;
    if (ns !== 3 || nr !== 4 || wb_mreg_o !== 1'b0) begin
      failures++;
      $display("FAIL sb_wait stalls=%0d reqs=%0d mreg=%b exp 3 4 0",
               ns, nr, wb_mreg_o);
    end
  endtask

  task automatic test_timeout();
    int nr, ns, ne;
    run_op(EXE_LB, 32'h300 | 32'($urandom_range(0, 3)), $urandom,
           $urandom, 99, 1, nr, ns, ne);
    checks++;
    if (ne !== 1 || ns !== TIMEOUT + 1 || wb_dm_o !== 32'h0 ||
        wb_mreg_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout errs=%0d stalls=%0d dm=%h mreg=%b exp 1 %0d 0 1",
               ne, ns, wb_dm_o, wb_mreg_o, TIMEOUT + 1);
    end
    run_op(EXE_LW, 32'h400, $urandom, 32'hCAFEF00D, 1, 0, nr, ns, ne);
    checks++;
    if (ns !== 1 || ne !== 0 || wb_dm_o !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL after_timeout stalls=%0d errs=%0d dm=%h exp 1 0 cafef00d",
               ns, ne, wb_dm_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_aluop_i = EXE_LW;
    mem_wd_i = 32'h0000_0500;
    mem_wa_i = 5'd7;
    mem_wreg_i = 1'b1;
    bus.dbus_ack_i = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (stall_req_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_wait_stall got=%b exp=1", stall_req_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dbus_req_o, stall_req_o, bus_err_o, wb_act} !== '0) begin
      failures++;
      $display("FAIL async_reset req=%b stall=%b err=%b wb=%h exp all 0",
               bus.dbus_req_o, stall_req_o, bus_err_o, wb_act);
    end
    bus.dbus_ack_i = 1'b1;
    bus.dbus_rdata_i = $urandom;
    @(posedge clk);
    #1;
    drive_nop();
    rst_n = 1'b1;
    exp_dm = 32'h0;
    #1;
    checks++;
    if ({bus.dbus_req_o, stall_req_o, bus_err_o} !== 3'b000) begin
      failures++;
      $display("FAIL late_ack_ctl got=%b%b%b exp=000",
               bus.dbus_req_o, stall_req_o, bus_err_o);
    end
    @(posedge clk);
    #1;
    bus.dbus_ack_i = 1'b0;
    checks++;
    if (wb_act !== '0) begin
      failures++;
      $display("FAIL late_ack_wb got=%h exp=0", wb_act);
    end
  endtask

  task automatic test_random();
    int nr, ns, ne;
    logic [7:0] op;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: op = EXE_LB;
        1: op = EXE_LW;
        2: op = EXE_SB;
        3: op = EXE_SW;
        default: op = 8'($urandom_range(0, 127));
      endcase
      run_op(op, $urandom, $urandom, $urandom,
             $urandom_range(0, TIMEOUT + 2), 1'($urandom),
             nr, ns, ne);
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    int nr, ns, ne;
    run_op(EXE_LW, 32'h102, $urandom, $urandom, 0, 0, nr, ns, ne);
    checks++;
    if (nr !== 0 || ns !== 0 || ne !== 1 || wb_wreg_o !== 1'b0) begin
      failures++;
      $display("FAIL align reqs=%0d stalls=%0d errs=%0d wreg=%b exp 0 0 1 0",
               nr, ns, ne, wb_wreg_o);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive_nop();
    bus.dbus_ack_i = 1'b0;
    bus.dbus_rdata_i = 32'h0;
    exp_dm = 32'h0;
    test_reset();
    test_lw_zero_wait();
    test_sb_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
